rnn_seq_ctrl: RTL
=================

# rnn_seq_ctrl

Timestep sequencer for the RNN accelerator. Over a requested number of timesteps it computes, column by column, h_new[j] = act(Σ_i x[i]·W[i][j] + Σ_k h[k]·U[k][j]) using one shared multiply-accumulate. Inputs are supplied one vector per step by handshake; the block fetches weights from the input-weight (W) and recurrent (U) matrix stores and holds the committed hidden state. It sits between the host register interface and the matrix storage.

## Interface
- IN_DIM, 2, input vector length (rows of W)
- HID_DIM, 4, hidden length (columns of W/U, rows of U)
- DW, 16, signed data/weight width
- ACC_W, 40, signed accumulator width
- FRAC, 8, fractional bits of the Q format
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sequence; sampled only in IDLE
- num_steps  in  8  timesteps, sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sequence end
- x_ready  out  1  high only in WAIT_X
- x_valid  in  1  input vector offered
- x_vec  in  IN_DIM*DW  packed input, element i at [i*DW +: DW]
- w_rd_en  out  1  weight read request
- w_sel  out  1  0 = W, 1 = U
- w_row, w_col  out  8  matrix indices
- w_data  in  DW  read data, valid exactly one cycle after w_rd_en
- h_rd_idx  in  8  hidden readout index
- h_rd_data  out  DW  committed h[h_rd_idx], combinational; 0 if index ≥ HID_DIM

## Operation
- States: IDLE, WAIT_X, ISSUE, DRAIN, WRITE, COMMIT, DONE.
- IDLE: on start with num_steps > 0, clear h and h_next to 0, load step counter, go to WAIT_X. With num_steps = 0, go to DONE; h is unchanged.
- WAIT_X: x_ready = 1; on x_valid, latch x_vec, set j = 0, k = 0, clear acc, go to ISSUE.
- ISSUE: one read per cycle for k = 0 … IN_DIM+HID_DIM−1. For k < IN_DIM: w_sel = 0, w_row = k. Otherwise: w_sel = 1, w_row = k−IN_DIM. w_col = j. The operand (x[k] or committed h[k−IN_DIM]) is delayed one cycle alongside the request. After the last issue, go to DRAIN.
- MAC: in the cycle after each issue, acc += sign-extended (operand × w_data). The product is 2·DW bits.
- DRAIN: the final MAC occurs here.
- WRITE:
  - r = acc >>> FRAC (arithmetic shift).
  - Saturate r to [−2^(DW−1), 2^(DW−1)−1].
  - Apply activation (see Configuration).
  - Store the result to h_next[j] and clear acc.
  - If j < HID_DIM−1: j++, k = 0, go to ISSUE. Otherwise go to COMMIT.
- COMMIT: h ← h_next; decrement the step counter. If steps remain, go to WAIT_X; otherwise go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- The recurrent term always uses the h committed at the previous step; h_next is never read back within a step.
- Ignored inputs: start outside IDLE; x_valid outside WAIT_X.
- Reset mid-operation returns the block to IDLE with all state cleared, and no done pulse. A read in flight is discarded.

## Timing
- Reset values: busy 0, done 0, x_ready 0, w_rd_en 0, w_sel 0, w_row 0, w_col 0; h, h_next and acc are 0, so h_rd_data is 0.
- start to busy = 1: next cycle. num_steps = 0: done is asserted 1 cycle after start.
- Each column takes (IN_DIM+HID_DIM) ISSUE cycles + 1 DRAIN + 1 WRITE.
- Each step, from the x handshake cycle to COMMIT, takes HID_DIM·(IN_DIM+HID_DIM+2)+1 cycles: 33 with the defaults.
- Handshake cycles: the x handshake is one cycle; x_ready falls in the following cycle.
- The final done pulse occurs the cycle after COMMIT.
- w_rd_en is high only in ISSUE. No read is issued in DRAIN or WRITE.
- h_rd_data changes only at COMMIT or clear.

## Configuration
- RNN_SEQ_RELU_EN defined: after saturation, negative results become 0 (ReLU).
- RNN_SEQ_RELU_EN undefined: the saturated linear result is stored unchanged.

## Structure
- Package rnn_seq_pkg holds:
  - the state enum;
  - the W_SEL = 0 / U_SEL = 1 constants;
  - the default dimension and width localparams.
- Sub-module rnn_sat_act: combinational shift, saturate and optional ReLU, parameterized by ACC_W, DW and FRAC. It is also reusable by other layers.

## Test plan
All scenarios use FRAC = 0 and the default dimensions.
- Reset: assert rst_n = 0 mid-ISSUE -> busy 0, w_rd_en 0, all h_rd_data 0, no done pulse.
- Linear step (macro off):
  - Stimulus: W rows {2,−10,−10,3}, {6,9,12,1}; U = 0; x = {2,−3}; num_steps = 1.
  - Response: h = {−14,−47,−56,3}; done arrives 33 cycles after the handshake cycle, plus 1.
- Recurrence (macro on):
  - Stimulus: same W; U row 3 = {−11,−4,3,−1}, other U rows 0; num_steps = 2; x = {2,−3} then {0,0}.
  - Response: after step 1, h = {0,0,0,3}; after step 2, h = {0,0,9,0}.
- Saturation: W all 32767, x = {32767,32767} -> h all 32767. Then negate W -> h all −32768 (macro off).
- Handshake and protocol:
  - Stimulus: hold x_valid low in WAIT_X for 10 cycles, and pulse start while busy.
  - Response: no w_rd_en and no state change while waiting; the start pulse is ignored; the result is unchanged.
- Zero steps: start with num_steps = 0 -> done the next cycle, no w_rd_en, h still 0.

Source files
------------

// File: rtl/rnn_seq_pkg.sv
// Shared state encoding, weight-store select codes and default sizes for the RNN timestep sequencer.
package rnn_seq_pkg;

    localparam int IN_DIM_DEF  = 2;
    localparam int HID_DIM_DEF = 4;
    localparam int DW_DEF      = 16;
    localparam int ACC_W_DEF   = 40;
    localparam int FRAC_DEF    = 8;

    localparam logic W_SEL = 1'b0;
    localparam logic U_SEL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_X,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_COMMIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/rnn_sat_act.sv
// Combinational Q-format rescale: arithmetic shift by FRAC, saturate to DW bits, then
// optional ReLU when RNN_SEQ_RELU_EN is defined. Zero latency, no flow control.
module rnn_sat_act #(
    parameter int ACC_W = 40,
    parameter int DW    = 16,
    parameter int FRAC  = 8
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [DW-1:0]    res_o
);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [ACC_W-1:0] shr;
    logic signed [DW-1:0]    sat;

    always_comb begin
        shr = acc_i >>> FRAC;
        if (shr > MAX_V) begin
            sat = MAX_V[DW-1:0];
        end else if (shr < MIN_V) begin
            sat = MIN_V[DW-1:0];
        end else begin
            sat = shr[DW-1:0];
        end
`ifdef RNN_SEQ_RELU_EN
        res_o = sat[DW-1] ? '0 : sat;
`else
        res_o = sat;
`endif
    end

endmodule

// File: rtl/rnn_seq_ctrl.sv
// RNN timestep sequencer: one shared MAC walks W then U per hidden column; step = HID*(IN+HID+2)+1 cycles.
// Stalls only in WAIT_X for the input vector; weight reads return fixed one cycle later (RNN_SEQ_RELU_EN in rnn_sat_act).
module rnn_seq_ctrl
    import rnn_seq_pkg::*;
#(
    parameter int IN_DIM  = IN_DIM_DEF,
    parameter int HID_DIM = HID_DIM_DEF,
    parameter int DW      = DW_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int FRAC    = FRAC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           num_steps,
    output logic                 busy,
    output logic                 done,
    output logic                 x_ready,
    input  logic                 x_valid,
    input  logic [IN_DIM*DW-1:0] x_vec,
    output logic                 w_rd_en,
    output logic                 w_sel,
    output logic [7:0]           w_row,
    output logic [7:0]           w_col,
    input  logic [DW-1:0]        w_data,
    input  logic [7:0]           h_rd_idx,
    output logic [DW-1:0]        h_rd_data
);
    localparam logic [7:0] K_LAST = 8'(IN_DIM + HID_DIM - 1);
    localparam logic [7:0] J_LAST = 8'(HID_DIM - 1);
    localparam logic [7:0] IN_N   = 8'(IN_DIM);

    state_e                     state_q, state_d;
    logic [7:0]                 steps_q, steps_d;
    logic [7:0]                 j_q, j_d;
    logic [7:0]                 k_q, k_d;
    logic [IN_DIM-1:0][DW-1:0]  x_q, x_d;
    logic [HID_DIM-1:0][DW-1:0] h_q, h_d;
    logic [HID_DIM-1:0][DW-1:0] hn_q, hn_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DW-1:0]       op_q, op_d;
    logic                       mac_q, mac_d;
    logic signed [2*DW-1:0]     prod;
    logic [DW-1:0]              act_res;

    assign prod = (2*DW)'(op_q) * (2*DW)'($signed(w_data));

    rnn_sat_act #(.ACC_W(ACC_W), .DW(DW), .FRAC(FRAC)) u_sat_act (
        .acc_i (acc_q),
        .res_o (act_res)
    );

    always_comb begin
        h_rd_data = '0;
        for (int i = 0; i < HID_DIM; i++) begin
            if (h_rd_idx == 8'(i)) h_rd_data = h_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        j_d     = j_q;
        k_d     = k_q;
        x_d     = x_q;
        h_d     = h_q;
        hn_d    = hn_q;
        op_d    = op_q;
        mac_d   = 1'b0;
        // The product of the previous cycle's issue lands one cycle later, including in DRAIN.
        acc_d   = mac_q ? acc_q + ACC_W'(prod) : acc_q;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        x_ready = 1'b0;
        w_rd_en = 1'b0;
        w_sel   = W_SEL;
        w_row   = '0;
        w_col   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_steps != 8'd0) begin
                        h_d     = '0;
                        hn_d    = '0;
                        steps_d = num_steps;
                        state_d = S_WAIT_X;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT_X: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    x_d     = x_vec;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_rd_en = 1'b1;
                mac_d   = 1'b1;
                w_col   = j_q;
                if (k_q < IN_N) begin
                    w_sel = W_SEL;
                    w_row = k_q;
                    for (int i = 0; i < IN_DIM; i++) begin
                        if (k_q == 8'(i)) op_d = x_q[i];
                    end
                end else begin
                    w_sel = U_SEL;
                    w_row = k_q - IN_N;
                    for (int i = 0; i < HID_DIM; i++) begin
                        if (k_q == 8'(i + IN_DIM)) op_d = h_q[i];
                    end
                end
                if (k_q == K_LAST) state_d = S_DRAIN;
                else               k_d     = k_q + 8'd1;
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                for (int i = 0; i < HID_DIM; i++) begin
                    if (j_q == 8'(i)) hn_d[i] = act_res;
                end
                acc_d = '0;
                if (j_q != J_LAST) begin
                    j_d     = j_q + 8'd1;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                h_d     = hn_q;
                steps_d = steps_q - 8'd1;
                state_d = (steps_q == 8'd1) ? S_DONE : S_WAIT_X;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            steps_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            x_q     <= '0;
            h_q     <= '0;
            hn_q    <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            mac_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            j_q     <= j_d;
            k_q     <= k_d;
            x_q     <= x_d;
            h_q     <= h_d;
            hn_q    <= hn_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            mac_q   <= mac_d;
        end
    end

endmodule
